// File: rtl/pulse_rate_meter_pkg.sv
// Shared constants and FSM state type for the pulse rate meter.
package pulse_rate_meter_pkg;

    localparam int DEFAULT_CLK_HZ      = 100_000_000;
    localparam int DEFAULT_GATE_CYCLES = DEFAULT_CLK_HZ;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/pulse_rate_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   delay_r;

    // Synchronizer chain plus one delay flop for edge detection.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            delay_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], async_in};
            delay_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Left combinational so a rise sampled at edge k is counted at edge k+SYNC_STAGES.
    assign edge_pulse = sync_r[SYNC_STAGES-1] & ~delay_r;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts rising edges of sig_in over a fixed gate window and shows the
// saturated count of the last completed window on LED.
module pulse_rate_meter
    import pulse_rate_meter_pkg::*;
#(
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               en,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] LED,
    output logic               ovf,
    output logic               done
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [GATE_W-1:0]   gate_r;
    logic [COUNT_W-1:0]  count_r;
    logic                sat_r;
    logic                edge_s;
    logic                measuring_s;
    logic                terminal_s;
    logic [COUNT_W:0]    sum_s;
    logic                sum_ovf_s;
    logic [COUNT_W-1:0]  sum_sat_s;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .async_in  (sig_in),
        .edge_pulse(edge_s)
    );

    // Next-state logic plus window/terminal decode and saturating sum.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_next_s = MEASURE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MEASURE: begin
                if (en) begin
                    state_next_s = MEASURE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase

        measuring_s = (state_r == MEASURE) && en;
        terminal_s  = measuring_s && (gate_r == GATE_LAST);
        // One extra bit catches the carry out of the count before clamping.
        sum_s       = {1'b0, count_r} + {{COUNT_W{1'b0}}, edge_s};
        sum_ovf_s   = sum_s[COUNT_W];
        if (sum_ovf_s) begin
            sum_sat_s = {COUNT_W{1'b1}};
        end else begin
            sum_sat_s = sum_s[COUNT_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Gate counter, edge counter and the per-window output registers.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            gate_r  <= {GATE_W{1'b0}};
            count_r <= {COUNT_W{1'b0}};
            sat_r   <= 1'b0;
            LED     <= {COUNT_W{1'b0}};
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (terminal_s) begin
                // An edge in the terminal cycle still belongs to the ending window.
                LED     <= sum_sat_s;
                ovf     <= sat_r | sum_ovf_s;
                done    <= 1'b1;
                gate_r  <= {GATE_W{1'b0}};
                count_r <= {COUNT_W{1'b0}};
                sat_r   <= 1'b0;
            end else if (measuring_s) begin
                gate_r <= gate_r + GATE_W'(1);
                if (sum_ovf_s) begin
                    sat_r <= 1'b1;
                end else begin
                    count_r <= sum_s[COUNT_W-1:0];
                end
            end else begin
                // Idle or leaving MEASURE: any partial window is discarded.
                gate_r  <= {GATE_W{1'b0}};
                count_r <= {COUNT_W{1'b0}};
                sat_r   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Scoreboard bench: stimulus queues expected LED/ovf/cycle per window, monitors pop on done.
module tb_pulse_rate_meter;

    typedef struct {
        int led;
        int ovf;
        int at;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en_a;
    logic       en_b;
    logic       sig;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic       ovf_a;
    logic       ovf_b;
    logic       done_a;
    logic       done_b;

    int   cyc;
    int   total;
    int   bad;
    int   period;
    int   gen_idx;
    exp_t q_a[$];
    exp_t q_b[$];

    pulse_rate_meter #(.GATE_CYCLES(100)) dut_a (
        .CLK100MHZ(clk),
        .reset    (reset),
        .en       (en_a),
        .sig_in   (sig),
        .LED      (led_a),
        .ovf      (ovf_a),
        .done     (done_a)
    );

    pulse_rate_meter #(.GATE_CYCLES(1200)) dut_b (
        .CLK100MHZ(clk),
        .reset    (reset),
        .en       (en_b),
        .sig_in   (sig),
        .LED      (led_b),
        .ovf      (ovf_b),
        .done     (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Square-wave source; period 0 means hold high.
    initial begin
        int p;
        sig     = 1'b0;
        gen_idx = 0;
        forever begin
            if (period == 0) begin
                sig     = 1'b1;
                gen_idx = 0;
                @(negedge clk);
            end else begin
                p = period;
                for (int i = 0; i < p; i++) begin
                    sig     = (i < p / 2);
                    gen_idx = i;
                    @(negedge clk);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_a(input int led, input int ovf, input int at);
        q_a.push_back('{led, ovf, at});
    endtask

    task automatic push_b(input int led, input int ovf, input int at);
        q_b.push_back('{led, ovf, at});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("a unexpected done", int'(done_a), 0);
                end else begin
                    e = q_a.pop_front();
                    check("a led", int'(led_a), e.led);
                    check("a ovf", int'(ovf_a), e.ovf);
                    check("a done cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("b unexpected done", int'(done_b), 0);
                end else begin
                    e = q_b.pop_front();
                    check("b led", int'(led_b), e.led);
                    check("b ovf", int'(ovf_b), e.ovf);
                    check("b done cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int c2;
        int cb;
        int r;
        total  = 0;
        bad    = 0;
        period = 10;
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        tick(5);
        check("reset led_a", int'(led_a), 0);
        check("reset ovf_a", int'(ovf_a), 0);
        check("reset done_a", int'(done_a), 0);
        check("reset led_b", int'(led_b), 0);
        check("reset ovf_b", int'(ovf_b), 0);
        reset = 1'b0;
        tick(20);

        // Period 10 over a 100-cycle window: 10 edges per window.
        c0   = cyc;
        en_a = 1'b1;
        push_a(10, 0, c0 + 101);
        push_a(10, 0, c0 + 201);
        push_a(10, 0, c0 + 301);
        go_to(c0 + 351);
        en_a = 1'b0;
        tick(30);
        check("a led held after abort", int'(led_a), 10);
        check("a ovf held after abort", int'(ovf_a), 0);
        c1   = cyc;
        en_a = 1'b1;
        push_a(10, 0, c1 + 101);

        // Reset mid-window while sig_in is low, en held high.
        go_to(c1 + 150);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (gen_idx == 6) break;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid reset led_a", int'(led_a), 0);
        check("mid reset ovf_a", int'(ovf_a), 0);
        check("mid reset done_a", int'(done_a), 0);
        reset = 1'b0;
        r     = cyc;
        push_a(10, 0, r + 101);
        go_to(r + 120);
        en_a = 1'b0;

        // Period 4 (2 high / 2 low): 25 edges per window.
        period = 4;
        tick(20);
        c2   = cyc;
        en_a = 1'b1;
        push_a(25, 0, c2 + 101);
        push_a(25, 0, c2 + 201);
        go_to(c2 + 210);
        en_a = 1'b0;

        // sig_in held high through reset: one synthetic edge, then none.
        period = 0;
        tick(10);
        en_a  = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        r     = cyc;
        push_a(1, 0, r + 101);
        push_a(0, 0, r + 201);
        go_to(r + 210);
        en_a = 1'b0;

        // 1200-cycle window: period 4 saturates, then period 12 gives 100.
        period = 4;
        tick(20);
        cb   = cyc;
        en_b = 1'b1;
        push_b(255, 1, cb + 1201);
        push_b(255, 1, cb + 2401);
        push_b(100, 0, cb + 3601);
        go_to(cb + 2201);
        period = 12;
        go_to(cb + 3606);
        en_b = 1'b0;
        tick(5);

        check("a expected windows seen", q_a.size(), 0);
        check("b expected windows seen", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
